riscv_fetch: RTL
================

RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of instruction buffer entries (fixed at 2).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port iaddr_o  output  32  instruction fetch address to instruction memory; bits [1:0] always 0.
REQ-007 SHALL have port ird_o  output  1  instruction read strobe; one fetch issued per cycle when high.
REQ-008 SHALL have port irdata_i  input  32  instruction word, valid exactly one cycle after the ird_o cycle.
REQ-009 SHALL have port redirect_i  input  1  branch/jump/trap redirect request.
REQ-010 SHALL have port redirect_pc_i  input  32  redirect target; bits [1:0] ignored.
REQ-011 SHALL have port inst_valid_o  output  1  instruction available to decode.
REQ-012 SHALL have port inst_o  output  32  instruction word at buffer head.
REQ-013 SHALL have port inst_pc_o  output  32  address of inst_o.
REQ-014 SHALL have port inst_ready_i  input  1  decode accepts; transfer when inst_valid_o & inst_ready_i.

Function
REQ-015 SHALL hold state: pc_r (next fetch address), inflight_r (1 bit: fetch issued last cycle, response due now), inflight_pc_r, 2-entry FIFO {inst, pc}, cnt_r (0..2).
REQ-016 SHALL drive iaddr_o = {pc_r[31:2], 2'b00} combinationally.
REQ-017 SHALL compute pop = inst_valid_o & inst_ready_i; occupancy = cnt_r + inflight_r - pop.
REQ-018 SHALL assert ird_o = ~reset_i & ~redirect_i & (occupancy < 2); ird_o depends combinationally on inst_ready_i.
REQ-019 On ird_o: pc_r <= pc_r + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); inflight_r <= 1; inflight_pc_r <= pc_r; else inflight_r <= 0.
REQ-020 When inflight_r=1 and no redirect: push {irdata_i, inflight_pc_r} into FIFO that cycle.
REQ-021 SHALL support push and pop in the same cycle, including at cnt_r=2 (pop frees slot before push); cnt_r never exceeds 2.
REQ-022 SHALL present FIFO head on inst_o/inst_pc_o; inst_valid_o = (cnt_r != 0); no bypass from irdata_i (fetch-to-decode latency 2 cycles).
REQ-023 SHALL keep inst_o/inst_pc_o stable while inst_valid_o=1 and inst_ready_i=0.
REQ-024 On redirect_i: FIFO flushed (cnt_r <= 0), response arriving that cycle discarded, ird_o=0, pc_r <= {redirect_pc_i[31:2],2'b00}, inflight_r <= 0; first fetch of target the next cycle.
REQ-025 Redirect with simultaneous pop: handshake counts as accepted by decode; flush still applies.
REQ-026 Back-to-back redirects: each overrides pc_r; only last target fetched.
REQ-027 With inst_ready_i held 1 and no redirect, SHALL sustain one instruction per cycle.

Reset
REQ-028 While reset_i=1: pc_r=RESET_PC, inflight_r=0, cnt_r=0, ird_o=0, inst_valid_o=0, iaddr_o=RESET_PC; inst_o/inst_pc_o SHALL read 0.
REQ-029 Reset mid-operation SHALL discard in-flight responses and buffer contents; first fetch in cycle after reset_i falls, at RESET_PC.

Verification
REQ-030 Reset release, ready=1, memory word i = 32'h1000_0000+i -> ird_o cycle 1 at 0x0, inst_valid_o cycle 3 with inst=0x10000000/pc=0x0, then pc 0x4,0x8,... one per cycle.
REQ-031 ready=0 from start -> exactly two fetches (0x0,0x4), ird_o low thereafter, cnt_r=2; ready=1 -> pcs 0x0,0x4,0x8 in order, none lost or duplicated.
REQ-032 Redirect to 0x0000_0103 while buffer full and a fetch in flight -> next iaddr_o=0x100, no instruction with pc 0x0..0xC delivered after redirect, first delivered pc=0x100.
REQ-033 Redirect asserted two consecutive cycles (0x200 then 0x300) -> only 0x300 fetched; no 0x200 instruction delivered.
REQ-034 RESET_PC=32'hFFFF_FFF8, ready=1 -> delivered pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-035 Random ready/redirect stress vs. reference PC model -> delivered pc sequence matches model, cnt_r<=2 always, inst stable while stalled.

Source files
------------

// File: rtl/riscv_fetch.sv
// riscv_fetch -- instruction fetch unit with a small prefetch buffer.
//
// Issues one word fetch per cycle to instruction memory while there is room
// for the answer, captures the response that arrives one cycle later, and
// hands {inst, pc} to decode through a valid/ready handshake. A redirect
// (branch/jump/trap) flushes everything already fetched and restarts the
// stream at the new target.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   iaddr_o        word-aligned fetch address
//   ird_o          fetch strobe, one fetch per cycle while high
//   irdata_i       fetched word, valid the cycle after ird_o
//   redirect_i     restart the stream
//   redirect_pc_i  restart target (low two bits ignored)
//   inst_valid_o   instruction available at the buffer head
//   inst_o         instruction word at the buffer head
//   inst_pc_o      address of inst_o
//   inst_ready_i   decode accepts the head this cycle
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] iaddr_o,
  output logic        ird_o,
  input  logic [31:0] irdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_r;
  logic         inflight_r;
  logic [31:0]  inflight_pc_r;
  fetch_entry_t fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] cnt_r;

  logic         pop, push;
  logic [CW:0]  occupancy;
  fetch_entry_t head;

  assign head = fifo_q[rd_ptr_r];

  assign inst_valid_o = ~reset_i & (cnt_r != '0);
  assign inst_o       = reset_i ? '0 : head.inst;
  assign inst_pc_o    = reset_i ? '0 : head.pc;
  assign iaddr_o      = reset_i ? (RESET_PC & 32'hFFFF_FFFC) : (pc_r & 32'hFFFF_FFFC);

  assign pop  = inst_valid_o & inst_ready_i;
  // A response landing in a redirect cycle belongs to the abandoned stream.
  assign push = inflight_r & ~redirect_i & ~reset_i;

  // Entries that will be held once the in-flight word lands, counting the
  // slot freed by this cycle's pop; a new fetch is only issued if its answer
  // is guaranteed a slot.
  assign occupancy = {1'b0, cnt_r} + (CW+1)'(inflight_r) - (CW+1)'(pop);
  assign ird_o     = ~reset_i & ~redirect_i & (occupancy < (CW+1)'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r          <= RESET_PC & 32'hFFFF_FFFC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      cnt_r         <= '0;
    end else if (redirect_i) begin
      pc_r       <= redirect_pc_i & 32'hFFFF_FFFC;
      inflight_r <= 1'b0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      cnt_r      <= '0;
    end else begin
      if (ird_o) begin
        pc_r          <= pc_r + 32'd4;
        inflight_r    <= 1'b1;
        inflight_pc_r <= pc_r;
      end else begin
        inflight_r <= 1'b0;
      end
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      cnt_r <= cnt_r + CW'(push) - CW'(pop);
    end
  end

  // Buffer payload needs no reset: outputs are masked during reset and
  // inst_valid_o qualifies the head otherwise.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_r] <= '{inst: irdata_i, pc: inflight_pc_r};
  end

endmodule
